mer_sweep_ctrl: RTL and testbench

MER_SWEEP_CTRL -- requirements
Module: mer_sweep_ctrl

---
 rtl/mer_sweep_ctrl_pkg.sv | 24 ++
 rtl/mer_sweep_ctrl_if.sv | 17 +
 rtl/mer_sweep_ctrl_sym_counter.sv | 29 ++
 rtl/mer_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_mer_sweep_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mer_sweep_ctrl_pkg.sv
// Shared types and constants for the MER sweep controller: FSM states and the
// ISI power table (20/30/40/55 dB) applied one entry per sweep level.
package mer_pkg;

   localparam int ISI_W = 18;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      ARM,
      MEASURE,
      CAPTURE,
      REPORT
   } state_t;

   localparam logic [3:0][ISI_W-1:0] LVL_TABLE = {18'd165, 18'd927, 18'd2931, 18'd9268};

   // Levels beyond the table reuse the last (weakest) ISI setting.
   function automatic logic [ISI_W-1:0] lvl_power(input int unsigned idx);
      return (idx > 32'd3) ? LVL_TABLE[3] : LVL_TABLE[idx[1:0]];
   endfunction

endpackage

// File: rtl/mer_sweep_ctrl_if.sv
// Result channel of the MER sweep controller: valid/ready handshake carrying
// the level index and the captured I/Q error-square sums.
interface mer_sweep_ctrl_if #(
   parameter int ERR_WID = 56,
   parameter int LVL_W   = 2
) ();

   logic               res_valid;
   logic               res_ready;
   logic [LVL_W-1:0]   res_lvl;
   logic [ERR_WID-1:0] res_i;
   logic [ERR_WID-1:0] res_q;

   modport master (output res_valid, res_lvl, res_i, res_q, input res_ready);
   modport slave  (input res_valid, res_lvl, res_i, res_q, output res_ready);

endinterface

// File: rtl/mer_sweep_ctrl_sym_counter.sv
// Symbol counter used for the post-load settle interval; tc fires combinationally
// on the TERM-th enabled symbol and the count wraps to zero there.
module sym_counter #(
   parameter int unsigned TERM = 16
) (
   input  logic sys_clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int unsigned CW = (TERM > 1) ? $clog2(TERM) : 1;

   logic [CW-1:0] cnt;

   assign tc = en && (cnt == CW'(TERM - 1));

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mer_sweep_ctrl.sv
// MER sweep controller: steps the DUT through NUM_LVL ISI power levels, measuring
// one LFSR period per level. Define MER_SWEEP_Q_EN to capture the Q error sum.
module mer_sweep_ctrl
   import mer_pkg::*;
#(
   parameter int NUM_LVL    = 4,
   parameter int SETTLE_SYM = 16,
   parameter int ERR_WID    = 56
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic               sym_clk_en,
   input  logic               start,
   input  logic               abort,
   input  logic               cycle,
   input  logic [ERR_WID-1:0] err_sq_i,
   input  logic [ERR_WID-1:0] err_sq_q,
   output logic               load,
   output logic               clr_acc,
   output logic [ISI_W-1:0]   isi_power,
   output logic               busy,
   output logic               done,
   mer_sweep_ctrl_if.master   res
);

   localparam int unsigned    LVL_W    = (NUM_LVL > 1) ? $clog2(NUM_LVL) : 1;
   localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LVL - 1);

   state_t             state;
   logic [LVL_W-1:0]   lvl;
   logic [ERR_WID-1:0] res_i_r;
   logic               mark;
   logic               settle_tc;

   assign mark    = cycle & sym_clk_en;
   assign load    = (state == LOAD) & sym_clk_en;
   assign clr_acc = ((state == ARM) || (state == MEASURE)) & mark;

   // Counter is held clear outside SETTLE, so every settle interval starts at 0.
   sym_counter #(.TERM(SETTLE_SYM)) u_settle (
      .sys_clk (sys_clk),
      .reset   (reset),
      .en      ((state == SETTLE) && sym_clk_en),
      .clr     (state != SETTLE),
      .tc      (settle_tc)
   );

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         lvl           <= '0;
         isi_power     <= LVL_TABLE[0];
         busy          <= 1'b0;
         done          <= 1'b0;
         res.res_valid <= 1'b0;
         res.res_lvl   <= '0;
         res_i_r       <= '0;
      end else begin
         done <= 1'b0;
         if (abort && (state != IDLE)) begin
            state         <= IDLE;
            busy          <= 1'b0;
            res.res_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state     <= LOAD;
                  lvl       <= '0;
                  isi_power <= lvl_power(32'd0);
                  busy      <= 1'b1;
               end
               LOAD:    if (sym_clk_en) state <= SETTLE;
               // A period marker on the terminal symbol only arms; it is not consumed here.
               SETTLE:  if (settle_tc) state <= ARM;
               ARM:     if (mark) state <= MEASURE;
               MEASURE: if (mark) state <= CAPTURE;
               CAPTURE: begin
                  res_i_r       <= err_sq_i;
                  res.res_lvl   <= lvl;
                  res.res_valid <= 1'b1;
                  state         <= REPORT;
               end
               REPORT: if (res.res_ready) begin
                  res.res_valid <= 1'b0;
                  if (lvl == LAST_LVL) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     lvl       <= lvl + LVL_W'(1);
                     isi_power <= lvl_power(32'(lvl) + 32'd1);
                     state     <= LOAD;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign res.res_i = res_i_r;

`ifdef MER_SWEEP_Q_EN
   logic [ERR_WID-1:0] res_q_r;

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         res_q_r <= '0;
      end else if ((state == CAPTURE) && !abort) begin
         res_q_r <= err_sq_q;
      end
   end

   assign res.res_q = res_q_r;
`else
   logic unused_err_q;
   assign unused_err_q = ^err_sq_q;
   assign res.res_q    = '0;
`endif

endmodule

// File: tb/tb_mer_sweep_ctrl.sv
// Self-checking bench for mer_sweep_ctrl: table-driven per-level vectors with a
// result scoreboard, plus stall, abort, reset and marker-coincidence sequences.
module tb_mer_sweep_ctrl;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        sym_clk_en = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        cycle = 1'b0;
   logic [55:0] err_sq_i = '0;
   logic [55:0] err_sq_q = '0;
   logic        load, clr_acc, busy, done;
   logic [17:0] isi_power;

   mer_sweep_ctrl_if #(.ERR_WID(56), .LVL_W(2)) res_if ();

   mer_sweep_ctrl #(.NUM_LVL(4), .SETTLE_SYM(16), .ERR_WID(56)) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .sym_clk_en (sym_clk_en),
      .start      (start),
      .abort      (abort),
      .cycle      (cycle),
      .err_sq_i   (err_sq_i),
      .err_sq_q   (err_sq_q),
      .load       (load),
      .clr_acc    (clr_acc),
      .isi_power  (isi_power),
      .busy       (busy),
      .done       (done),
      .res        (res_if.master)
   );

   typedef struct {
      logic [55:0] ei;
      logic [55:0] eq;
      logic [1:0]  lvl;
      logic [17:0] isi;
   } vec_t;

   typedef struct {
      logic [1:0]  lvl;
      logic [55:0] ri;
      logic [55:0] rq;
      logic [17:0] isi;
   } exp_t;

   vec_t vecs[4];
   exp_t sb[$];

   int tests = 0, fails = 0;
   int load_cnt = 0, clr_cnt = 0, done_cnt = 0, hs_cnt = 0;
   int load_base = 0, clr_base = 0;
   bit coinc = 1'b0;
   int period = 64;
   int symcnt = 0, since_load = 0, div = 0;

   initial forever #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Symbol strobe every 4th clock; cycle marker either free-running every
   // `period` symbols, or locked so it lands on the 16th symbol after each load.
   initial forever begin
      @(posedge sys_clk);
      #1;
      div        = (div + 1) % 4;
      sym_clk_en = (div == 0);
      if (sym_clk_en) begin
         symcnt++;
         since_load++;
         if (coinc) cycle = (since_load >= 16) && (((since_load - 16) % period) == 0);
         else       cycle = ((symcnt % period) == 0);
      end else begin
         cycle = 1'b0;
      end
      @(negedge sys_clk);
      if (load) since_load = 0;
   end

   initial begin : mon
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (load)    load_cnt++;
         if (clr_acc) clr_cnt++;
         if (done)    done_cnt++;
         if (res_if.res_valid && res_if.res_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_result", 64'(res_if.res_lvl), 64'hDEAD);
            end else begin
               e = sb.pop_front();
               check("res_lvl", 64'(res_if.res_lvl), 64'(e.lvl));
               check("res_i", 64'(res_if.res_i), 64'(e.ri));
               check("res_q", 64'(res_if.res_q), 64'(e.rq));
               check("isi_power", 64'(isi_power), 64'(e.isi));
               check("load_per_lvl", 64'(load_cnt - load_base), 64'd1);
               check("clr_per_lvl", 64'(clr_cnt - clr_base), 64'd2);
               load_base = load_cnt;
               clr_base  = clr_cnt;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic drive_level(input int k, input int salt);
      exp_t e;
      err_sq_i = vecs[k].ei ^ 56'(salt);
      err_sq_q = vecs[k].eq;
      e.lvl = vecs[k].lvl;
      e.ri  = vecs[k].ei ^ 56'(salt);
`ifdef MER_SWEEP_Q_EN
      e.rq  = vecs[k].eq;
`else
      e.rq  = '0;
`endif
      e.isi = vecs[k].isi;
      sb.push_back(e);
   endtask

   task automatic wait_hs(input int target, input int budget);
      int c = 0;
      while (hs_cnt < target && c < budget) begin
         @(negedge sys_clk);
         c++;
      end
      if (hs_cnt < target) check("hs_timeout", 64'(hs_cnt), 64'(target));
   endtask

   task automatic stall_check();
      int c = 0;
      int lc;
      while (!res_if.res_valid && c < 5000) begin
         @(negedge sys_clk);
         c++;
      end
      check("stall_valid_seen", 64'(res_if.res_valid), 64'd1);
      lc = load_cnt;
      err_sq_i = ~err_sq_i;
      err_sq_q = ~err_sq_q;
      for (int i = 0; i < 50; i++) begin
         @(negedge sys_clk);
         check("stall_valid", 64'(res_if.res_valid), 64'd1);
         check("stall_res_i", 64'(res_if.res_i), 64'(sb[0].ri));
         check("stall_res_q", 64'(res_if.res_q), 64'(sb[0].rq));
         check("stall_res_lvl", 64'(res_if.res_lvl), 64'(sb[0].lvl));
      end
      check("stall_no_load", 64'(load_cnt), 64'(lc));
      @(posedge sys_clk);
      #1 res_if.res_ready = 1'b1;
   endtask

   task automatic do_abort();
      int c = 0;
      int cb = clr_cnt;
      int db = done_cnt;
      while (clr_cnt == cb && c < 5000) begin
         @(negedge sys_clk);
         c++;
      end
      check("abort_measure_reached", 64'(clr_cnt - cb), 64'd1);
      tick(10);
      @(posedge sys_clk);
      #1 abort = 1'b1;
      @(posedge sys_clk);
      #1 abort = 1'b0;
      @(negedge sys_clk);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_clr_acc", 64'(clr_acc), 64'd0);
      check("abort_res_valid", 64'(res_if.res_valid), 64'd0);
      tick(30);
      check("abort_no_done", 64'(done_cnt), 64'(db));
      check("abort_idle_busy", 64'(busy), 64'd0);
      sb.delete();
   endtask

   task automatic do_reset();
      int c = 0;
      int lb = load_cnt;
      int db = done_cnt;
      while (load_cnt == lb && c < 5000) begin
         @(negedge sys_clk);
         c++;
      end
      check("reset_load_seen", 64'(load_cnt - lb), 64'd1);
      tick(8);
      #2 reset = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_load", 64'(load), 64'd0);
      check("rst_clr_acc", 64'(clr_acc), 64'd0);
      check("rst_res_valid", 64'(res_if.res_valid), 64'd0);
      check("rst_res_lvl", 64'(res_if.res_lvl), 64'd0);
      check("rst_res_i", 64'(res_if.res_i), 64'd0);
      check("rst_res_q", 64'(res_if.res_q), 64'd0);
      check("rst_isi_power", 64'(isi_power), 64'd9268);
      tick(2);
      reset = 1'b1;
      tick(20);
      check("rst_no_done", 64'(done_cnt), 64'(db));
      sb.delete();
   endtask

   task automatic do_run(input bit stall, input int abort_lvl, input int reset_lvl, input int salt);
      int base = hs_cnt;
      int db = done_cnt;
      bit stopped = 1'b0;
      drive_level(0, salt);
      if (stall) res_if.res_ready = 1'b0;
      @(posedge sys_clk);
      #1 start = 1'b1;
      load_base = load_cnt;
      clr_base  = clr_cnt;
      @(posedge sys_clk);
      #1 start = 1'b0;
      for (int k = 0; k < 4 && !stopped; k++) begin
         if (k > 0) drive_level(k, salt);
         if (k == abort_lvl) begin
            do_abort();
            stopped = 1'b1;
         end else if (k == reset_lvl) begin
            do_reset();
            stopped = 1'b1;
         end else begin
            if (stall && k == 0) stall_check();
            wait_hs(base + k + 1, 5000);
         end
      end
      if (!stopped) begin
         tick(3);
         check("done_once", 64'(done_cnt - db), 64'd1);
         check("busy_after_run", 64'(busy), 64'd0);
         check("queue_empty", 64'(sb.size()), 64'd0);
      end
   endtask

   initial begin
      vecs[0] = '{ei: 56'h00123456789ABC, eq: 56'hFFFFFFFFFFFFFF, lvl: 2'd0, isi: 18'd9268};
      vecs[1] = '{ei: 56'hA5A5A5A5A5A5A5, eq: 56'h00000000000001, lvl: 2'd1, isi: 18'd2931};
      vecs[2] = '{ei: 56'h80000000000000, eq: 56'h0F1E2D3C4B5A69, lvl: 2'd2, isi: 18'd927};
      vecs[3] = '{ei: 56'hFFFFFFFFFFFFFF, eq: 56'hFFFFFFFFFFFFFF, lvl: 2'd3, isi: 18'd165};

      reset = 1'b0;
      res_if.res_ready = 1'b1;
      #22;
      check("init_busy", 64'(busy), 64'd0);
      check("init_done", 64'(done), 64'd0);
      check("init_load", 64'(load), 64'd0);
      check("init_clr_acc", 64'(clr_acc), 64'd0);
      check("init_res_valid", 64'(res_if.res_valid), 64'd0);
      check("init_res_lvl", 64'(res_if.res_lvl), 64'd0);
      check("init_res_i", 64'(res_if.res_i), 64'd0);
      check("init_res_q", 64'(res_if.res_q), 64'd0);
      check("init_isi_power", 64'(isi_power), 64'd9268);
      @(negedge sys_clk);
      reset = 1'b1;
      tick(4);

      coinc = 1'b0; period = 64;
      do_run(1'b0, -1, -1, 0);

      coinc = 1'b1; period = 16;
      do_run(1'b1, -1, -1, 'h11);

      do_run(1'b0, 2, -1, 'h22);
      do_run(1'b0, -1, 1, 'h33);
      do_run(1'b0, -1, -1, 'h44);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
      $fatal(1);
   end

endmodule
